// File: rtl/row_col_dram_pkg.sv
// Shared sizing constants and types for the row/column decoded storage array.
package row_col_dram_pkg;

    localparam int ROW_BITS = 4;
    localparam int COL_BITS = 4;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = ROW_BITS + COL_BITS;
    localparam int NUM_ROWS = 1 << ROW_BITS;
    localparam int NUM_COLS = 1 << COL_BITS;

    typedef logic [ROW_BITS-1:0] row_t;
    typedef logic [COL_BITS-1:0] col_t;
    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [ADDR_W-1:0]   addr_t;

endpackage

// File: rtl/row_col_decoder.sv
// Splits the flat address into row and column fields and decodes each to one-hot.
module row_col_decoder
    import row_col_dram_pkg::*;
(
    input  logic [ADDR_W-1:0]   addr,
    output logic [NUM_ROWS-1:0] row_sel,
    output logic [NUM_COLS-1:0] col_sel
);

    row_t row_s;
    col_t col_s;

    assign row_s = addr[ADDR_W-1:COL_BITS];
    assign col_s = addr[COL_BITS-1:0];

    // One-hot decode of the row and column fields
    always_comb begin
        row_sel        = {NUM_ROWS{1'b0}};
        col_sel        = {NUM_COLS{1'b0}};
        row_sel[row_s] = 1'b1;
        col_sel[col_s] = 1'b1;
    end

endmodule

// File: rtl/row_col_dram.sv
// Single-port 256 x 8 storage array with row/column one-hot cell selection,
// synchronous writes and one-cycle registered reads.
module row_col_dram
    import row_col_dram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              write_en,
    output logic [DATA_W-1:0] rdata
);

    logic [NUM_ROWS-1:0] row_sel_s;
    logic [NUM_COLS-1:0] col_sel_s;

    logic [NUM_ROWS-1:0][NUM_COLS-1:0][DATA_W-1:0] mem_q;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0][DATA_W-1:0] mem_d;
    data_t rdata_q;
    data_t rdata_d;
    data_t rd_mux_s;

    row_col_decoder u_decoder (
        .addr    (addr),
        .row_sel (row_sel_s),
        .col_sel (col_sel_s)
    );

    // Cell write gating and AND-OR read mux; a cell is live only where row and column selects meet
    always_comb begin
        mem_d    = mem_q;
        rd_mux_s = {DATA_W{1'b0}};
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                mem_d[r][c] = (write_en & row_sel_s[r] & col_sel_s[c]) ? wdata : mem_q[r][c];
                rd_mux_s    = rd_mux_s | ({DATA_W{row_sel_s[r] & col_sel_s[c]}} & mem_q[r][c]);
            end
        end
        rdata_d = write_en ? rdata_q : rd_mux_s;
    end

    // Array and read-data state; reset clears every cell and wins over a write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q   <= '0;
            rdata_q <= {DATA_W{1'b0}};
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_row_col_dram.sv
// Scoreboard bench: each driven cycle queues the rdata required after its edge;
// a monitor pops at that edge and compares on the following falling edge.
module tb_row_col_dram;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       write_en;
    logic [7:0] rdata;

    typedef struct {
        bit         chk;
        logic [7:0] exp;
        logic [7:0] a;
        int         tag;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    row_col_dram dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .wdata    (wdata),
        .write_en (write_en),
        .rdata    (rdata)
    );

    always #5 clk = ~clk;

    // tag: 0 reset, 1 read, 2 write-hold
    task automatic drive(input logic rst, input logic we, input logic [7:0] a,
                         input logic [7:0] d, input bit chk, input logic [7:0] exp, input int tag);
        exp_t e;
        rst_n    = rst;
        write_en = we;
        addr     = a;
        wdata    = d;
        e.chk = chk;
        e.exp = exp;
        e.a   = a;
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp);
        drive(1'b1, 1'b0, a, 8'h00, 1'b1, exp, 1);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic [7:0] hold);
        drive(1'b1, 1'b1, a, d, 1'b1, hold, 2);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                @(negedge clk);
                if (e.chk) begin
                    chk_cnt++;
                    if (rdata === e.exp) begin
                        pass_cnt++;
                    end else begin
                        $display("FAIL cyc_tag%0d addr=%02h rdata got=%02h exp=%02h",
                                 e.tag, e.a, rdata, e.exp);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] a8;
        logic [7:0] sum8;
        int wait_cyc;
        rst_n    = 1'b0;
        write_en = 1'b0;
        addr     = 8'h00;
        wdata    = 8'h00;
        @(posedge clk);
        #1;

        // reset held for two cycles
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 0);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 0);
        rd(8'h00, 8'h00);
        rd(8'h5A, 8'h00);
        rd(8'hFF, 8'h00);

        // full fill with row+col; rdata must hold 0 throughout
        for (int i = 0; i < 256; i++) begin
            a8   = 8'(i);
            sum8 = {4'h0, a8[7:4]} + {4'h0, a8[3:0]};
            wr(a8, sum8, 8'h00);
        end
        for (int i = 0; i < 256; i++) begin
            a8   = 8'(i);
            sum8 = {4'h0, a8[7:4]} + {4'h0, a8[3:0]};
            rd(a8, sum8);
        end
        rd(8'h37, 8'h0A);
        rd(8'hFF, 8'h1E);

        // reset mid-operation together with a write: write ignored, array cleared
        drive(1'b0, 1'b1, 8'hFF, 8'h77, 1'b1, 8'h00, 0);
        rd(8'hFF, 8'h00);
        rd(8'h37, 8'h00);

        // decoder isolation
        wr(8'h34, 8'hAA, 8'h00);
        rd(8'h34, 8'hAA);
        rd(8'h43, 8'h00);
        rd(8'h24, 8'h00);
        rd(8'h35, 8'h00);

        // hold during write
        rd(8'h34, 8'hAA);
        wr(8'h10, 8'h55, 8'hAA);
        rd(8'h10, 8'h55);

        // pipelined back-to-back reads
        wr(8'h01, 8'h11, 8'h55);
        wr(8'h02, 8'h22, 8'h55);
        wr(8'h03, 8'h33, 8'h55);
        rd(8'h01, 8'h11);
        rd(8'h02, 8'h22);
        rd(8'h03, 8'h33);

        write_en = 1'b0;
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        @(posedge clk);
        @(posedge clk);
        chk_cnt++;
        if (exp_q.size() == 0) begin
            pass_cnt++;
        end else begin
            $display("FAIL drain pending got=%0d exp=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
